// File: rtl/uart_tx_serializer_if.sv
// TX handshake between the UART register controller and the serial transmit engine.
// The controller drives the byte and the level start request, and the serializer
// answers with the start-clear pulse and the holding-register busy flag.
interface uart_tx_serializer_if;
    logic [7:0] i_tx_data;
    logic       i_tx_start;
    logic       o_tx_start_clear;
    logic       o_tx_busy;

    modport master (
        output i_tx_data,
        output i_tx_start,
        input  o_tx_start_clear,
        input  o_tx_busy
    );

    modport slave (
        input  i_tx_data,
        input  i_tx_start,
        output o_tx_start_clear,
        output o_tx_busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-byte holding register feeding an LSB-first shifter.
// Sends 8N1/8N2 frames by default. Defining UART_TX_PARITY_EN inserts an even parity
// bit after D7, giving 8E1/8E2 frames.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_serializer_if.slave  i_tx_if,
    output logic                 o_tx_active,
    output logic                 o_tx_done,
    output logic                 o_tx
);

    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_hold;
    logic             r_hold_valid;
    logic             r_clear;
    logic             r_clear_d;
    logic             w_bit_end;
    logic             w_accept;
    logic             w_load;
    logic             w_tx;
    logic             w_done;

    // Start is ignored while the clear pulse is out and one cycle after it, so the
    // controller's registered request has dropped before it is sampled again.
    assign w_accept  = i_tx_if.i_tx_start & ~r_hold_valid & ~r_clear & ~r_clear_d;
    assign w_bit_end = (r_cnt == LAST_CNT);

    assign i_tx_if.o_tx_start_clear = r_clear;
    assign i_tx_if.o_tx_busy        = r_hold_valid;
    assign o_tx_active              = (r_state != S_IDLE);
    assign o_tx                     = w_tx;
    assign o_tx_done                = w_done;

    // Holding register, accept handshake and start-clear guard pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_clear      <= 1'b0;
            r_clear_d    <= 1'b0;
        end else begin
            r_clear   <= w_accept;
            r_clear_d <= r_clear;
            if (w_load) begin
                r_hold_valid <= 1'b0;
            end else if (w_accept) begin
                r_hold       <= i_tx_if.i_tx_data;
                r_hold_valid <= 1'b1;
            end
        end
    end

    // Shifter is loaded from the holding register when a frame begins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (w_load) begin
            r_shift <= r_hold;
        end
    end

    // Bit-time counter, 0..CLKS_PER_BIT-1, parked at zero while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE || w_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Bit index within the current state: data bit number, or stop bit number
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_idx <= '0;
        end else if (w_state_next != r_state) begin
            r_bit_idx <= '0;
        end else if (w_bit_end) begin
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, line level, transfer strobe and done pulse
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_tx         = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hold_valid) begin
                    w_state_next = S_START;
                    w_load       = 1'b1;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx = r_shift[r_bit_idx];
                if (w_bit_end && r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx = ^r_shift;
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end && r_bit_idx == LAST_STOP) begin
                    w_done = 1'b1;
                    // A queued byte starts its frame with no idle bit in between.
                    if (r_hold_valid) begin
                        w_state_next = S_START;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer. Build with UART_TX_PARITY_EN defined to
// exercise the 8E2 configuration; otherwise 8N1 is used.
module tb_uart_tx_serializer;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned STOP = 2;
    localparam int unsigned PAR  = 1;
`else
    localparam int unsigned STOP = 1;
    localparam int unsigned PAR  = 0;
`endif
    localparam int FRAME = int'((1 + 8 + PAR + STOP) * CPB);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic o_tx_active;
    logic o_tx_done;
    logic o_tx;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_serializer_if tx_if ();

    uart_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (STOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tx_if     (tx_if),
        .o_tx_active (o_tx_active),
        .o_tx_done   (o_tx_done),
        .o_tx        (o_tx)
    );

    always #5 clk = ~clk;

    // Expected line level at cycle c of a frame carrying byte b: the frame is a list of
    // bits (start, D0..D7, optional even parity, stop bits), each CPB cycles long.
    function automatic logic model_tx(input logic [7:0] b, input int c);
        int bit_no;
        if (c < 0 || c >= FRAME) return 1'b1;
        bit_no = c / int'(CPB);
        if (bit_no == 0) return 1'b0;
        if (bit_no <= 8) return b[bit_no-1];
        if (PAR == 1 && bit_no == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic test_reset();
        logic [7:0] b;
        int errs;
        int bad_c;
        b = 8'($urandom);
        rst_n = 1'b0;
        tx_if.i_tx_data  = b;
        tx_if.i_tx_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({o_tx, tx_if.o_tx_busy, tx_if.o_tx_start_clear, o_tx_active, o_tx_done} !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: tx/busy/clr/act/done=%b%b%b%b%b expected 10000", i,
                         o_tx, tx_if.o_tx_busy, tx_if.o_tx_start_clear, o_tx_active, o_tx_done);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_if.o_tx_start_clear !== 1'b1 || tx_if.o_tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_accept: clr=%b busy=%b expected 1 1", tx_if.o_tx_start_clear, tx_if.o_tx_busy);
        end
        tx_if.i_tx_start = 1'b0;
        errs = 0;
        bad_c = -1;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (o_tx !== model_tx(b, c) || o_tx_active !== 1'b1 || o_tx_done !== (c == FRAME - 1)) begin
                errs++;
                if (bad_c < 0) bad_c = c;
            end
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL reset_frame byte %h: %0d bad cycles, first at %0d, expected 0", b, errs, bad_c);
        end
    endtask

    task automatic test_single();
        logic [7:0] bytes [6];
        int errs;
        int bad_c;
        logic got_tx;
        logic exp_tx;
        bytes[0] = 8'hA5;
        bytes[1] = 8'h07;
        for (int k = 2; k < 6; k++) bytes[k] = 8'($urandom);
        foreach (bytes[k]) begin
            tx_if.i_tx_data  = bytes[k];
            tx_if.i_tx_start = 1'b1;
            @(negedge clk);
            n_checks++;
            if (tx_if.o_tx_start_clear !== 1'b1 || tx_if.o_tx_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_accept %h: clr=%b busy=%b expected 1 1", bytes[k],
                         tx_if.o_tx_start_clear, tx_if.o_tx_busy);
            end
            tx_if.i_tx_start = 1'b0;
            errs = 0;
            bad_c = -1;
            got_tx = 1'b0;
            exp_tx = 1'b0;
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                if (o_tx !== model_tx(bytes[k], c) || o_tx_active !== 1'b1 ||
                    o_tx_done !== (c == FRAME - 1) || tx_if.o_tx_start_clear !== 1'b0 ||
                    tx_if.o_tx_busy !== 1'b0) begin
                    errs++;
                    if (bad_c < 0) begin
                        bad_c = c;
                        got_tx = o_tx;
                        exp_tx = model_tx(bytes[k], c);
                    end
                end
            end
            n_checks++;
            if (errs != 0) begin
                n_fail++;
                $display("FAIL single_frame %h: %0d bad cycles, first at %0d (tx=%b expected %b)",
                         bytes[k], errs, bad_c, got_tx, exp_tx);
            end
            @(negedge clk);
            n_checks++;
            if (o_tx !== 1'b1 || o_tx_active !== 1'b0 || o_tx_done !== 1'b0) begin
                n_fail++;
                $display("FAIL single_idle %h: tx=%b act=%b done=%b expected 1 0 0", bytes[k],
                         o_tx, o_tx_active, o_tx_done);
            end
        end
    endtask

    // b1 is requested after sample r of the first frame; it must queue and follow with no gap.
    task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1, input int r);
        int errs;
        int bad_c;
        logic exp_tx;
        tx_if.i_tx_data  = b0;
        tx_if.i_tx_start = 1'b1;
        @(negedge clk);
        tx_if.i_tx_start = 1'b0;
        errs = 0;
        bad_c = -1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            exp_tx = (c < FRAME) ? model_tx(b0, c) : model_tx(b1, c - FRAME);
            if (o_tx !== exp_tx || o_tx_active !== 1'b1 ||
                o_tx_done !== (c == FRAME - 1 || c == 2 * FRAME - 1) ||
                tx_if.o_tx_start_clear !== (c == r + 1) ||
                tx_if.o_tx_busy !== (c >= r + 1 && c < FRAME)) begin
                errs++;
                if (bad_c < 0) bad_c = c;
            end
            if (tx_if.o_tx_start_clear === 1'b1) tx_if.i_tx_start = 1'b0;
            if (c == r) begin
                tx_if.i_tx_data  = b1;
                tx_if.i_tx_start = 1'b1;
            end
        end
        tx_if.i_tx_start = 1'b0;
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL back_to_back %h,%h r=%0d: %0d bad cycles, first at %0d, expected 0",
                     b0, b1, r, errs, bad_c);
        end
        @(negedge clk);
        n_checks++;
        if (o_tx !== 1'b1 || o_tx_active !== 1'b0 || tx_if.o_tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_idle: tx=%b act=%b busy=%b expected 1 0 0",
                     o_tx, o_tx_active, tx_if.o_tx_busy);
        end
    endtask

    // Third request is raised while the holding register is full and must wait for it.
    task automatic test_busy_block();
        logic [7:0] bytes [3];
        int errs;
        int bad_c;
        int blocked_clears;
        int fr;
        for (int k = 0; k < 3; k++) bytes[k] = 8'($urandom);
        tx_if.i_tx_data  = bytes[0];
        tx_if.i_tx_start = 1'b1;
        @(negedge clk);
        tx_if.i_tx_start = 1'b0;
        errs = 0;
        bad_c = -1;
        blocked_clears = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            fr = c / FRAME;
            if (c >= 5 && c <= FRAME && tx_if.o_tx_start_clear === 1'b1) blocked_clears++;
            if (o_tx !== model_tx(bytes[fr], c - fr * FRAME) || o_tx_active !== 1'b1 ||
                o_tx_done !== ((c % FRAME) == FRAME - 1) ||
                tx_if.o_tx_start_clear !== (c == 2 || c == FRAME + 1) ||
                tx_if.o_tx_busy !== ((c >= 2 && c < FRAME) || (c >= FRAME + 1 && c < 2 * FRAME))) begin
                errs++;
                if (bad_c < 0) bad_c = c;
            end
            if (tx_if.o_tx_start_clear === 1'b1) tx_if.i_tx_start = 1'b0;
            if (c == 1) begin
                tx_if.i_tx_data  = bytes[1];
                tx_if.i_tx_start = 1'b1;
            end
            if (c == 4) begin
                tx_if.i_tx_data  = bytes[2];
                tx_if.i_tx_start = 1'b1;
            end
        end
        tx_if.i_tx_start = 1'b0;
        n_checks++;
        if (blocked_clears != 0) begin
            n_fail++;
            $display("FAIL busy_block_clear: %0d clears while full, expected 0", blocked_clears);
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL busy_block_frames %h,%h,%h: %0d bad cycles, first at %0d, expected 0",
                     bytes[0], bytes[1], bytes[2], errs, bad_c);
        end
        @(negedge clk);
        n_checks++;
        if (o_tx !== 1'b1 || o_tx_active !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_block_idle: tx=%b act=%b expected 1 0", o_tx, o_tx_active);
        end
    endtask

    task automatic test_reset_midframe();
        int errs;
        int cut;
        logic [7:0] b;
        b = 8'($urandom);
        cut = 4 * int'(CPB) + 1;
        tx_if.i_tx_data  = 8'h0F;
        tx_if.i_tx_start = 1'b1;
        @(negedge clk);
        tx_if.i_tx_start = 1'b0;
        errs = 0;
        for (int c = 0; c <= cut; c++) begin
            @(negedge clk);
            if (o_tx !== model_tx(8'h0F, c) || o_tx_active !== 1'b1) errs++;
            if (tx_if.o_tx_start_clear === 1'b1) tx_if.i_tx_start = 1'b0;
            if (c == 1) begin
                tx_if.i_tx_data  = b;
                tx_if.i_tx_start = 1'b1;
            end
        end
        tx_if.i_tx_start = 1'b0;
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL midframe_prefix: %0d bad cycles, expected 0", errs);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_tx !== 1'b1 || o_tx_active !== 1'b0 || o_tx_done !== 1'b0 || tx_if.o_tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: tx=%b act=%b done=%b busy=%b expected 1 0 0 0",
                     o_tx, o_tx_active, o_tx_done, tx_if.o_tx_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_tx_active !== 1'b0 || o_tx_done !== 1'b0 || tx_if.o_tx_busy !== 1'b0) errs++;
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL midframe_discard: %0d cycles not idle after reset, expected 0", errs);
        end
    endtask

    initial begin
        tx_if.i_tx_data  = '0;
        tx_if.i_tx_start = 1'b0;
        test_reset();
        test_single();
        test_back_to_back(8'h00, 8'hFF, int'(CPB) + 2);
        test_back_to_back(8'($urandom), 8'($urandom), int'($urandom_range(9 * CPB - 2, CPB)));
        test_busy_block();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
